ws_array_feeder: RTL and testbench

- Upstream feeder for the weight-stationary PE grid (ROWS x COLS of 8-bit PEs).
- Loads one weight row per beat into a weight bank, then drives every PE's weight input continuously and stably.
- Accepts activation vectors over a valid/ready handshake and skews them diagonally, so row r enters the array r cycles after row 0.
- Drains the array with zeros and pulses done, leaving the PE partial-sum chain (top in_c tied to 0) fully flushed.

---
 rtl/ws_array_feeder_if.sv | 44 ++++
 rtl/ws_array_feeder.sv | 105 ++++++++++
 tb/tb_ws_array_feeder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ws_array_feeder_if.sv
// Handshake and data bundle between the weight-stationary array feeder and its host/PE grid.
// start_reuse exists only when FEEDER_WREUSE_EN is defined.
interface ws_array_feeder_if #(
  parameter int SIZE = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  logic                       start;
`ifdef FEEDER_WREUSE_EN
  logic                       start_reuse;
`endif
  logic                       w_valid;
  logic                       w_ready;
  logic [COLS*SIZE-1:0]       w_data;
  logic                       act_valid;
  logic                       act_ready;
  logic                       act_last;
  logic [ROWS*SIZE-1:0]       act_data;
  logic [ROWS*SIZE-1:0]       out_a;
  logic [ROWS-1:0]            out_a_valid;
  logic [ROWS*COLS*SIZE-1:0]  out_b;
  logic                       busy;
  logic                       done;

`ifdef FEEDER_WREUSE_EN
  modport slave (
    input  start, start_reuse, w_valid, w_data, act_valid, act_last, act_data,
    output w_ready, act_ready, out_a, out_a_valid, out_b, busy, done
  );
  modport master (
    output start, start_reuse, w_valid, w_data, act_valid, act_last, act_data,
    input  w_ready, act_ready, out_a, out_a_valid, out_b, busy, done
  );
`else
  modport slave (
    input  start, w_valid, w_data, act_valid, act_last, act_data,
    output w_ready, act_ready, out_a, out_a_valid, out_b, busy, done
  );
  modport master (
    output start, w_valid, w_data, act_valid, act_last, act_data,
    input  w_ready, act_ready, out_a, out_a_valid, out_b, busy, done
  );
`endif
endinterface

// File: rtl/ws_array_feeder.sv
// Weight-stationary array feeder: loads a weight bank, skews activations diagonally, drains with zeros.
// Optional FEEDER_WREUSE_EN adds start_reuse to restart streaming with the current weight bank.
//
// state  | meaning
// IDLE   | waiting for start (or start_reuse), skew lines flushing zeros
// LOAD_W | accepting one weight row per w_valid beat into the bank
// STREAM | accepting activation vectors, bubbles inject zeros
// DRAIN  | injecting zeros for ROWS+COLS-1 cycles, done on the last one
module ws_array_feeder #(
  parameter int SIZE = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic               clk,
  input  logic               reset,
  ws_array_feeder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  localparam int WCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DCW = $clog2(ROWS + COLS);
  localparam logic [WCW-1:0] W_LAST = WCW'(ROWS - 1);
  localparam logic [DCW-1:0] D_LAST = DCW'(ROWS + COLS - 2);

  state_t               state_q;
  logic [WCW-1:0]       w_cnt_q;
  logic [DCW-1:0]       d_cnt_q;
  logic [COLS*SIZE-1:0] bank_q [ROWS];
  logic                 act_fire;

  assign act_fire      = (state_q == STREAM) && bus.act_valid;
  assign bus.w_ready   = (state_q == LOAD_W);
  assign bus.act_ready = (state_q == STREAM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DRAIN) && (d_cnt_q == D_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      w_cnt_q <= '0;
      d_cnt_q <= '0;
      for (int r = 0; r < ROWS; r++) bank_q[r] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= LOAD_W;
            w_cnt_q <= '0;
          end
`ifdef FEEDER_WREUSE_EN
          else if (bus.start_reuse) begin
            state_q <= STREAM;
          end
`endif
        end
        LOAD_W: begin
          if (bus.w_valid) begin
            bank_q[w_cnt_q] <= bus.w_data;
            w_cnt_q         <= w_cnt_q + 1'b1;
            if (w_cnt_q == W_LAST) state_q <= STREAM;
          end
        end
        STREAM: begin
          if (bus.act_valid && bus.act_last) begin
            state_q <= DRAIN;
            d_cnt_q <= '0;
          end
        end
        DRAIN: begin
          if (d_cnt_q == D_LAST) state_q <= IDLE;
          else                   d_cnt_q <= d_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lane r is an (r+1)-deep delay line; zeros shift in whenever no vector is accepted.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [SIZE-1:0] d_q [r+1];
    logic            v_q [r+1];

    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int k = 0; k <= r; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= act_fire ? bus.act_data[r*SIZE +: SIZE] : '0;
        v_q[0] <= act_fire;
        for (int k = 1; k <= r; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign bus.out_a[r*SIZE +: SIZE]           = d_q[r];
    assign bus.out_a_valid[r]                  = v_q[r];
    assign bus.out_b[r*COLS*SIZE +: COLS*SIZE] = bank_q[r];
  end

endmodule

// File: tb/tb_ws_array_feeder.sv
// Self-checking bench for ws_array_feeder: per-cycle comparison against a behavioural model,
// directed literal checks, and randomized runs (FEEDER_WREUSE_EN exercises start_reuse when defined).
module tb_ws_array_feeder;
  localparam int SIZE = 8;
  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 0;

  ws_array_feeder_if #(.SIZE(SIZE), .ROWS(ROWS), .COLS(COLS)) bus ();

  ws_array_feeder #(.SIZE(SIZE), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 loading, 2 streaming, 3 draining
  int                    m_mode = 0;
  int                    m_wrow = 0;
  int                    m_left = 0;
  logic [SIZE-1:0]       m_bank [ROWS][COLS];
  logic [ROWS*SIZE-1:0]  hist_vec [ROWS];
  logic                  hist_v [ROWS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic fire;
    logic reuse;
    if (!reset) begin
      m_mode = 0; m_wrow = 0; m_left = 0;
      for (int r = 0; r < ROWS; r++) begin
        hist_vec[r] = '0; hist_v[r] = 1'b0;
        for (int c = 0; c < COLS; c++) m_bank[r][c] = '0;
      end
    end else begin
      fire = (m_mode == 2) && bus.act_valid;
`ifdef FEEDER_WREUSE_EN
      reuse = bus.start_reuse;
`else
      reuse = 1'b0;
`endif
      // out_a row r = vector injected r edges ago
      for (int k = ROWS - 1; k > 0; k--) begin
        hist_vec[k] = hist_vec[k-1]; hist_v[k] = hist_v[k-1];
      end
      hist_vec[0] = fire ? bus.act_data : '0;
      hist_v[0]   = fire;
      case (m_mode)
        0: if (bus.start) begin m_mode = 1; m_wrow = 0; end
           else if (reuse) m_mode = 2;
        1: if (bus.w_valid) begin
             for (int c = 0; c < COLS; c++) m_bank[m_wrow][c] = bus.w_data[c*SIZE +: SIZE];
             m_wrow++;
             if (m_wrow == ROWS) m_mode = 2;
           end
        2: if (fire && bus.act_last) begin m_mode = 3; m_left = ROWS + COLS - 1; end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [ROWS*SIZE-1:0]      ea;
    logic [ROWS-1:0]           ev;
    logic [ROWS*COLS*SIZE-1:0] eb;
    if (chk_en) begin
      for (int r = 0; r < ROWS; r++) begin
        ea[r*SIZE +: SIZE] = hist_vec[r][r*SIZE +: SIZE];
        ev[r] = hist_v[r];
        for (int c = 0; c < COLS; c++) eb[(r*COLS + c)*SIZE +: SIZE] = m_bank[r][c];
      end
      check("out_a", 256'(bus.out_a), 256'(ea));
      check("out_a_valid", 256'(bus.out_a_valid), 256'(ev));
      check("out_b", 256'(bus.out_b), 256'(eb));
      check("busy_done_wrdy_ardy", 256'({bus.busy, bus.done, bus.w_ready, bus.act_ready}),
            256'({m_mode != 0, (m_mode == 3) && (m_left == 1), m_mode == 1, m_mode == 2}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.w_valid = 0; bus.w_data = '0;
    bus.act_valid = 0; bus.act_last = 0; bus.act_data = '0;
`ifdef FEEDER_WREUSE_EN
    bus.start_reuse = 0;
`endif
  endtask

  task automatic load_weights(input logic [COLS*SIZE-1:0] rows [ROWS], input bit gap);
    bus.start = 1; tick(); bus.start = 0;
    for (int r = 0; r < ROWS; r++) begin
      bus.w_valid = 1; bus.w_data = rows[r]; tick();
      bus.w_valid = 0;
      if (gap) tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (m_mode != 0 && cyc < 200) begin tick(); cyc++; end
    check(name, 256'(cyc < 200), 256'(1));
  endtask

  task automatic rand_run(input int nvec, input bit do_rst, input bit reuse);
    int sent = 0;
    int cyc  = 0;
`ifdef FEEDER_WREUSE_EN
    if (reuse) bus.start_reuse = 1; else bus.start = 1;
`else
    bus.start = 1;
`endif
    tick(); idle_inputs();
    while (m_mode == 1 && cyc < 200) begin
      bus.w_valid   = ($urandom_range(0, 2) != 0);
      bus.w_data    = $urandom;
      bus.act_valid = $urandom_range(0, 1);
      bus.act_data  = $urandom;
      tick(); cyc++;
    end
    while (m_mode == 2 && cyc < 400) begin
      bus.act_valid = ($urandom_range(0, 3) != 0);
      bus.act_data  = $urandom;
      bus.act_last  = bus.act_valid && (sent == nvec - 1);
      bus.start     = $urandom_range(0, 1);
      bus.w_valid   = $urandom_range(0, 1);
      bus.w_data    = $urandom;
      if (do_rst && sent == 1) reset = 0;
      tick(); cyc++;
      if (bus.act_valid) sent++;
      reset = 1;
    end
    idle_inputs();
    check("rand_run_bound", 256'(cyc < 400), 256'(1));
    wait_idle("rand_drain_bound");
  endtask

  logic [COLS*SIZE-1:0] wrows [ROWS];
  int off;

  initial begin
    reset = 0;
    idle_inputs();
    wrows[0] = 32'h04030201; wrows[1] = 32'h08070605;
    wrows[2] = 32'h0C0B0A09; wrows[3] = 32'h100F0E0D;

    tick(); chk_en = 1;
    tick(); tick();
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_out_b", 256'(bus.out_b), 256'(0));
    check("rst_out_a", 256'({bus.out_a, bus.out_a_valid, bus.done}), 256'(0));
    reset = 1;
    tick(); tick();
    check("post_rst_idle", 256'({bus.busy, bus.out_a, bus.out_b}), 256'(0));

    load_weights(wrows, 1'b1);
    check("pe_2_1", 256'(bus.out_b[(2*COLS+1)*SIZE +: SIZE]), 256'(8'h0A));
    check("pe_3_3", 256'(bus.out_b[(3*COLS+3)*SIZE +: SIZE]), 256'(8'h10));
    check("stream_after_load", 256'({bus.act_ready, bus.w_ready}), 256'(2'b10));

    bus.act_valid = 1; bus.act_data = 32'h44332211; tick();
    check("lane0_first", 256'(bus.out_a[7:0]), 256'(8'h11));
    check("lane0_valid", 256'(bus.out_a_valid), 256'(4'b0001));
    bus.act_data = 32'h88776655; bus.act_last = 1; tick();
    idle_inputs();
    check("enter_drain", 256'({bus.busy, bus.act_ready}), 256'(2'b10));
    tick(); tick();
    check("lane3_first", 256'(bus.out_a[31:24]), 256'(8'h44));
    check("lane3_valid_first", 256'(bus.out_a_valid), 256'(4'b1100));
    tick();
    check("lane3_second", 256'(bus.out_a[31:24]), 256'(8'h88));
    check("lane3_valid_second", 256'(bus.out_a_valid), 256'(4'b1000));
    off = 3;
    while (!bus.done && off < 20) begin tick(); off++; end
    check("done_offset", 256'(off), 256'(ROWS + COLS - 2));
    check("busy_with_done", 256'(bus.busy), 256'(1));
    tick();
    check("after_done", 256'({bus.busy, bus.done, bus.out_a, bus.out_a_valid}), 256'(0));
    check("bank_held", 256'(bus.out_b[(3*COLS+3)*SIZE +: SIZE]), 256'(8'h10));

    // bubbles mid-stream
    load_weights(wrows, 1'b0);
    bus.act_valid = 1; bus.act_data = 32'hA4A3A2A1; tick();
    bus.act_valid = 0; tick();
    check("bubble_lane0", 256'({bus.out_a[7:0], bus.out_a_valid[0]}), 256'(0));
    tick();
    bus.act_valid = 1; bus.act_last = 1; bus.act_data = 32'hB4B3B2B1; tick();
    idle_inputs();
    wait_idle("bubble_drain_bound");

    // reset mid-stream
    load_weights(wrows, 1'b0);
    bus.act_valid = 1; bus.act_data = 32'h5A5A5A5A; tick();
    bus.act_valid = 0; reset = 0; tick();
    reset = 1;
    check("midrst_all_zero", 256'({bus.busy, bus.done, bus.out_a, bus.out_a_valid}), 256'(0));
    check("midrst_bank", 256'(bus.out_b), 256'(0));
    tick();
    check("midrst_no_done", 256'({bus.busy, bus.done}), 256'(0));

`ifdef FEEDER_WREUSE_EN
    load_weights(wrows, 1'b0);
    bus.act_valid = 1; bus.act_last = 1; bus.act_data = 32'h01020304; tick();
    idle_inputs();
    wait_idle("reuse_prep_bound");
    bus.start_reuse = 1; tick(); bus.start_reuse = 0;
    check("reuse_stream", 256'({bus.act_ready, bus.w_ready}), 256'(2'b10));
    check("reuse_bank", 256'(bus.out_b[(2*COLS+1)*SIZE +: SIZE]), 256'(8'h0A));
    bus.act_valid = 1; bus.act_last = 1; tick();
    idle_inputs();
    wait_idle("reuse_drain_bound");
    bus.start = 1; bus.start_reuse = 1; tick(); idle_inputs();
    check("start_wins", 256'(bus.w_ready), 256'(1));
    reset = 0; tick(); reset = 1; tick();
`endif

    for (int i = 0; i < 30; i++) begin
      rand_run($urandom_range(1, 6), ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 3)) begin
        bus.w_valid = $urandom_range(0, 1); bus.act_valid = $urandom_range(0, 1);
        bus.act_data = $urandom; tick();
      end
      idle_inputs();
    end

    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
